// File: rtl/wdt_timer_param_if.sv
// Avalon-MM slave bus bundle for the parametrised watchdog timer.
// The CPU side (or testbench) drives through the master modport; the
// watchdog core attaches to the slave modport. irq and resetrequest travel
// with the bus so the whole peripheral boundary is one connection.
interface wdt_timer_param_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;
    logic        resetrequest;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq, resetrequest
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq, resetrequest
    );
endinterface

// File: rtl/wdt_timer_param.sv
// Parametrised Avalon-MM watchdog timer, 16-bit data bus.
// Programmable period, keyed kick register, early-warning interrupt,
// sticky lock bit and a stretched reset-request pulse.
// Optional feature macro: WDT_SNAPSHOT_EN builds the counter snapshot
// register behind SNAPL/SNAPH; without it those addresses read 0.
module wdt_timer_param #(
    parameter int          COUNTER_WIDTH      = 32,
    parameter int          DEFAULT_PERIOD     = 9999999,
    parameter int          RESET_PULSE_CYCLES = 16,
    parameter logic [15:0] KICK_KEY           = 16'hA5C3
) (
    input logic                clk,
    input logic                reset_n,
    wdt_timer_param_if.slave   bus
);

    localparam int PW = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(RESET_PULSE_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] PERIOD_INIT = COUNTER_WIDTH'(DEFAULT_PERIOD);

    logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
    logic [COUNTER_WIDTH-1:0] period_q, period_d;
    logic [15:0]              ewThresh_q, ewThresh_d;
    logic                     run_q, run_d;
    logic                     to_q, to_d;
    logic                     ew_q, ew_d;
    logic                     ito_q, ito_d;
    logic                     eie_q, eie_d;
    logic                     lock_q, lock_d;
    logic                     forceReload_q, forceReload_d;
    logic                     zeroPrev_q, zeroPrev_d;
    logic                     pulseActive_q, pulseActive_d;
    logic [PW-1:0]            pulseCnt_q, pulseCnt_d;
    logic [15:0]              readdata_q, readMux;

    logic                     wr, wrStatus, wrControl, wrPeriodL, wrPeriodH, wrKick, wrThresh;
    logic                     kick, keyFault, counterZero, timeoutEvent, reload, ewHit;
    logic [COUNTER_WIDTH-1:0] counterDec, threshExt;
    logic [31:0]              periodExt, snapExt;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wrStatus  = wr & (bus.address == 3'd0);
    assign wrControl = wr & (bus.address == 3'd1);
    assign wrPeriodL = wr & (bus.address == 3'd2);
    assign wrPeriodH = wr & (bus.address == 3'd3);
    assign wrKick    = wr & (bus.address == 3'd6);
    assign wrThresh  = wr & (bus.address == 3'd7);

    assign kick         = wrKick & run_q & (bus.writedata == KICK_KEY);
    assign keyFault     = wrKick & run_q & (bus.writedata != KICK_KEY);
    assign counterZero  = (counter_q == '0);
    assign timeoutEvent = (counterZero & ~zeroPrev_q) | keyFault;
    assign reload       = forceReload_q | kick;
    assign counterDec   = counter_q - COUNTER_WIDTH'(1);
    assign threshExt    = {{(COUNTER_WIDTH-16){1'b0}}, ewThresh_q};
    assign ewHit        = run_q & ~reload & ~counterZero & (counterDec == threshExt)
                          & (ewThresh_q != 16'd0);

    // Next-state for counter, period, flags, control bits and pulse stretcher
    always_comb begin
        counter_d     = counter_q;
        period_d      = period_q;
        ewThresh_d    = ewThresh_q;
        run_d         = run_q;
        to_d          = to_q;
        ew_d          = ew_q;
        ito_d         = ito_q;
        eie_d         = eie_q;
        lock_d        = lock_q;
        forceReload_d = 1'b0;
        zeroPrev_d    = counterZero;
        pulseActive_d = pulseActive_q;
        pulseCnt_d    = pulseCnt_q;

        if (reload) begin
            counter_d = period_q;
        end else if (run_q && counterZero) begin
            counter_d = period_q;
        end else if (run_q) begin
            counter_d = counterDec;
        end

        if (timeoutEvent) begin
            to_d = 1'b1;
        end else if (wrStatus && bus.writedata[0]) begin
            to_d = 1'b0;
        end

        if (ewHit) begin
            ew_d = 1'b1;
        end else if (wrStatus && bus.writedata[2]) begin
            ew_d = 1'b0;
        end

        if (wrControl) begin
            if (!lock_q) begin
                ito_d = bus.writedata[0];
                eie_d = bus.writedata[1];
            end
            if (bus.writedata[2]) begin
                run_d = 1'b1;
            end else if (bus.writedata[3] && !lock_q) begin
                run_d = 1'b0;
            end
            if (bus.writedata[4]) begin
                lock_d = 1'b1;
            end
        end

        if (wrPeriodL && !lock_q) begin
            period_d[15:0] = bus.writedata;
            forceReload_d  = 1'b1;
        end
        if (wrPeriodH && !lock_q) begin
            period_d[COUNTER_WIDTH-1:16] = bus.writedata[COUNTER_WIDTH-17:0];
            forceReload_d                = 1'b1;
        end

        if (wrThresh) begin
            ewThresh_d = bus.writedata;
        end

        if (timeoutEvent) begin
            pulseActive_d = 1'b1;
            pulseCnt_d    = PULSE_LAST;
        end else if (pulseActive_q) begin
            if (pulseCnt_q == '0) begin
                pulseActive_d = 1'b0;
            end else begin
                pulseCnt_d = pulseCnt_q - PW'(1);
            end
        end
    end

    // State registers, cleared asynchronously by reset_n
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter_q     <= PERIOD_INIT;
            period_q      <= PERIOD_INIT;
            ewThresh_q    <= '0;
            run_q         <= 1'b0;
            to_q          <= 1'b0;
            ew_q          <= 1'b0;
            ito_q         <= 1'b0;
            eie_q         <= 1'b0;
            lock_q        <= 1'b0;
            forceReload_q <= 1'b0;
            zeroPrev_q    <= 1'b0;
            pulseActive_q <= 1'b0;
            pulseCnt_q    <= '0;
        end else begin
            counter_q     <= counter_d;
            period_q      <= period_d;
            ewThresh_q    <= ewThresh_d;
            run_q         <= run_d;
            to_q          <= to_d;
            ew_q          <= ew_d;
            ito_q         <= ito_d;
            eie_q         <= eie_d;
            lock_q        <= lock_d;
            forceReload_q <= forceReload_d;
            zeroPrev_q    <= zeroPrev_d;
            pulseActive_q <= pulseActive_d;
            pulseCnt_q    <= pulseCnt_d;
        end
    end

`ifdef WDT_SNAPSHOT_EN
    logic                     wrSnapL;
    logic [COUNTER_WIDTH-1:0] snap_q;

    assign wrSnapL = wr & (bus.address == 3'd4);

    // Capture the live counter on any SNAPL write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_q <= '0;
        end else if (wrSnapL) begin
            snap_q <= counter_q;
        end
    end

    // Zero-extend the snapshot to the 32-bit register view
    always_comb begin
        snapExt                   = '0;
        snapExt[COUNTER_WIDTH-1:0] = snap_q;
    end
`else
    assign snapExt = '0;
`endif

    // Zero-extend the period so bits above COUNTER_WIDTH read back as 0
    always_comb begin
        periodExt                    = '0;
        periodExt[COUNTER_WIDTH-1:0] = period_q;
    end

    // Register-map read multiplexer
    always_comb begin
        readMux = '0;
        case (bus.address)
            3'd0: readMux = {13'd0, ew_q, run_q, to_q};
            3'd1: readMux = {11'd0, lock_q, 2'b00, eie_q, ito_q};
            3'd2: readMux = periodExt[15:0];
            3'd3: readMux = periodExt[31:16];
            3'd4: readMux = snapExt[15:0];
            3'd5: readMux = snapExt[31:16];
            3'd7: readMux = ewThresh_q;
            default: readMux = '0;
        endcase
    end

    // Registered read data, refreshed every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= readMux;
        end
    end

    assign bus.readdata     = readdata_q;
    assign bus.irq          = (to_q & ito_q) | (ew_q & eie_q);
    assign bus.resetrequest = pulseActive_q;

endmodule
